// File: rtl/fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fu_wb_arbiter
//  Description : Write-back arbiter for the multi-cycle functional units.
//                Captures each unit's one-cycle finish pulse into a private
//                holding register, then grants one holding register per
//                cycle (round-robin) onto the single register-file write
//                port. Reports per-unit pending status and a sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_wb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_FU-1:0]                           fu_finish,
    input  logic [NUM_FU*RD_W-1:0]                      fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]                    fu_data,
    output logic [NUM_FU-1:0]                           fu_pending,
    output logic                                        wb_en,
    output logic [RD_W-1:0]                             wb_rd,
    output logic [DATA_W-1:0]                           wb_data,
    output logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] wb_src,
    output logic                                        ovf
);

    localparam int c_SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Holding registers, one per functional unit
    logic [NUM_FU-1:0]  r_valid;
    logic [RD_W-1:0]    r_hold_rd   [NUM_FU];
    logic [DATA_W-1:0]  r_hold_data [NUM_FU];

    // Most recently granted unit; the search for the next grant starts after it
    logic [c_SRC_W-1:0] r_last;
    logic               r_ovf;

    // Arbitration results
    logic               w_gnt_vld;
    logic [c_SRC_W-1:0] w_gnt_idx;
    logic [c_SRC_W-1:0] w_cand;
    logic [NUM_FU-1:0]  w_gnt;
    logic               w_ovf_evt;

    // Round-robin search over valid entries, starting at last+1 and wrapping
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_FU; k++) begin
            w_cand = c_SRC_W'((int'(r_last) + k) % NUM_FU);
            if (!w_gnt_vld && r_valid[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // One-hot form of the grant, used by the per-unit capture logic
    always_comb begin
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // A finish into an occupied entry that is not being drained this cycle
    // has nowhere to go; the newer result is the one that is lost
    assign w_ovf_evt = |(fu_finish & r_valid & ~w_gnt);

    // Capture finishes; a granted entry frees and may reload in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_hold_rd[i]   <= '0;
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_finish[i] && (!r_valid[i] || w_gnt[i])) begin
                    r_valid[i]     <= 1'b1;
                    r_hold_rd[i]   <= fu_rd[i*RD_W +: RD_W];
                    r_hold_data[i] <= fu_data[i*DATA_W +: DATA_W];
                end else if (w_gnt[i]) begin
                    r_valid[i]     <= 1'b0;
                end
            end
        end
    end

    // Register the granted entry onto the write port; rd=0 uses the slot but never writes x0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_src  <= '0;
            r_last  <= c_SRC_W'(NUM_FU - 1);
        end else if (w_gnt_vld) begin
            wb_en   <= |r_hold_rd[w_gnt_idx];
            wb_rd   <= r_hold_rd[w_gnt_idx];
            wb_data <= r_hold_data[w_gnt_idx];
            wb_src  <= w_gnt_idx;
            r_last  <= w_gnt_idx;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end
    end

    assign fu_pending = r_valid;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_wb_arbiter
//  Description : Self-checking bench for fu_wb_arbiter: directed scenarios
//                followed by randomized finishes, all compared every cycle
//                against a queue-free behavioural model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_wb_arbiter;

    localparam int NUM_FU = 4;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    logic                     clk;
    logic                     rst;
    logic [NUM_FU-1:0]        fu_finish;
    logic [NUM_FU*RD_W-1:0]   fu_rd;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_pending;
    logic                     wb_en;
    logic [RD_W-1:0]          wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic [1:0]               wb_src;
    logic                     ovf;

    fu_wb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fu_finish  (fu_finish),
        .fu_rd      (fu_rd),
        .fu_data    (fu_data),
        .fu_pending (fu_pending),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_src     (wb_src),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus for the next edge
    logic [NUM_FU-1:0] s_fin;
    logic [RD_W-1:0]   s_rd   [NUM_FU];
    logic [DATA_W-1:0] s_data [NUM_FU];

    // Behavioural model: one slot per unit plus the visible write port
    bit                m_valid [NUM_FU];
    logic [RD_W-1:0]   m_rd    [NUM_FU];
    logic [DATA_W-1:0] m_data  [NUM_FU];
    int                m_last;
    logic              m_wb_en;
    logic [RD_W-1:0]   m_wb_rd;
    logic [DATA_W-1:0] m_wb_data;
    logic [1:0]        m_wb_src;
    logic              m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_valid[i] = 1'b0;
            m_rd[i]    = '0;
            m_data[i]  = '0;
        end
        m_last    = NUM_FU - 1;
        m_wb_en   = 1'b0;
        m_wb_rd   = '0;
        m_wb_data = '0;
        m_wb_src  = '0;
        m_ovf     = 1'b0;
    endtask

    // Which unit the next edge writes back: first occupied slot after the last winner
    function automatic int model_grant();
        for (int k = 1; k <= NUM_FU; k++) begin
            if (m_valid[(m_last + k) % NUM_FU]) return (m_last + k) % NUM_FU;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (g >= 0) begin
            m_wb_en    = (m_rd[g] != 0);
            m_wb_rd    = m_rd[g];
            m_wb_data  = m_data[g];
            m_wb_src   = 2'(g);
            m_last     = g;
            m_valid[g] = 1'b0;
        end else begin
            m_wb_en = 1'b0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (s_fin[i]) begin
                if (!m_valid[i]) begin
                    m_valid[i] = 1'b1;
                    m_rd[i]    = s_rd[i];
                    m_data[i]  = s_data[i];
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        logic [NUM_FU-1:0] pend;
        for (int i = 0; i < NUM_FU; i++) pend[i] = m_valid[i];
        check({tag, ".pending"}, 32'(fu_pending), 32'(pend));
        check({tag, ".wb_en"},   32'(wb_en),      32'(m_wb_en));
        check({tag, ".wb_rd"},   32'(wb_rd),      32'(m_wb_rd));
        check({tag, ".wb_data"}, wb_data,         m_wb_data);
        check({tag, ".wb_src"},  32'(wb_src),     32'(m_wb_src));
        check({tag, ".ovf"},     32'(ovf),        32'(m_ovf));
    endtask

    // Drive s_* for one edge, advance the model, compare #1 after the edge
    task automatic step(input string tag);
        fu_finish = s_fin;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_rd[i*RD_W +: RD_W]       = s_rd[i];
            fu_data[i*DATA_W +: DATA_W] = s_data[i];
        end
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(tag);
        s_fin = '0;
    endtask

    task automatic reset_sync();
        rst       = 1'b1;
        fu_finish = '0;
        s_fin     = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cmp_all("reset");
    endtask

    task automatic rand_inputs(input bit polite);
        int g;
        g = model_grant();
        for (int i = 0; i < NUM_FU; i++) begin
            s_fin[i]  = ($urandom_range(0, 9) < 3);
            if (polite && m_valid[i] && g != i) s_fin[i] = 1'b0;
            s_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s_data[i] = $urandom;
        end
    endtask

    initial begin
        rst       = 1'b1;
        fu_finish = '0;
        fu_rd     = '0;
        fu_data   = '0;
        s_fin     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            s_rd[i]   = '0;
            s_data[i] = '0;
        end
        model_reset();
        @(posedge clk);
        reset_sync();

        // Single result on unit 1
        s_fin = 4'b0010; s_rd[1] = 5'd7; s_data[1] = 32'hDEADBEEF;
        step("single_cap");
        check("single_pend1", 32'(fu_pending[1]), 32'd1);
        check("single_noen",  32'(wb_en), 32'd0);
        step("single_wb");
        check("single_en",    32'(wb_en), 32'd1);
        check("single_rd",    32'(wb_rd), 32'd7);
        check("single_data",  wb_data, 32'hDEADBEEF);
        check("single_src",   32'(wb_src), 32'd1);
        check("single_clr",   32'(fu_pending[1]), 32'd0);
        step("single_after");
        check("single_en_low", 32'(wb_en), 32'd0);

        // Four-way collision straight after reset
        reset_sync();
        s_fin = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) begin
            s_rd[i]   = 5'(i + 1);
            s_data[i] = $urandom;
        end
        step("coll_cap");
        for (int k = 0; k < NUM_FU; k++) begin
            step("coll_wb");
            check("coll_src", 32'(wb_src), 32'(k));
            check("coll_rd",  32'(wb_rd),  32'(k + 1));
        end
        step("coll_idle");
        check("coll_ovf", 32'(ovf), 32'd0);

        // Fairness: unit 0 refires whenever its slot is free or being drained
        reset_sync();
        for (int c = 0; c < 12; c++) begin
            s_fin[0] = (!m_valid[0] || model_grant() == 0);
            s_rd[0]  = 5'(c + 1); s_data[0] = $urandom;
            if (c == 1) begin
                s_fin[2] = 1'b1; s_rd[2] = 5'd9; s_data[2] = 32'h0000_2222;
            end
            step("fair");
        end
        check("fair_ovf", 32'(ovf), 32'd0);
        for (int c = 0; c < 4; c++) step("drain");

        // rd = 0 consumes a slot without writing
        s_fin = 4'b1000; s_rd[3] = 5'd0; s_data[3] = 32'h1234;
        step("rd0_cap");
        check("rd0_pend", 32'(fu_pending[3]), 32'd1);
        step("rd0_slot");
        check("rd0_en",   32'(wb_en), 32'd0);
        check("rd0_clr",  32'(fu_pending[3]), 32'd0);
        s_fin = 4'b0001; s_rd[0] = 5'd5; s_data[0] = 32'h5555;
        step("rd0_next_cap");
        step("rd0_next_wb");
        check("rd0_next_en",  32'(wb_en), 32'd1);
        check("rd0_next_src", 32'(wb_src), 32'd0);

        // Overflow: unit 1 refires while its first result waits behind unit 0
        reset_sync();
        s_fin = 4'b0011;
        s_rd[0] = 5'd10; s_data[0] = 32'h1111;
        s_rd[1] = 5'd11; s_data[1] = 32'h2222;
        step("ovf_T");
        s_fin = 4'b0010; s_rd[1] = 5'd12; s_data[1] = 32'h0000AAAA;
        step("ovf_T1");
        check("ovf_set", 32'(ovf), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step("ovf_drain");
            check("ovf_no_aaaa", 32'(wb_data !== 32'h0000AAAA), 32'd1);
            check("ovf_sticky",  32'(ovf), 32'd1);
        end

        // Asynchronous reset with three entries in flight
        reset_sync();
        s_fin = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            s_rd[i] = 5'(i + 20); s_data[i] = $urandom;
        end
        step("arst_cap");
        step("arst_wb");
        #2;
        rst = 1'b1;
        #1;
        check("arst_en",   32'(wb_en), 32'd0);
        check("arst_pend", 32'(fu_pending), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_all("arst_rel");
        s_fin = 4'b1001; s_rd[0] = 5'd3; s_rd[3] = 5'd6;
        step("arst_prio_cap");
        step("arst_prio_wb");
        check("arst_prio_src", 32'(wb_src), 32'd0);

        // Random traffic respecting fu_pending: must never overflow
        reset_sync();
        for (int c = 0; c < 200; c++) begin
            rand_inputs(1'b1);
            step("rand_polite");
        end
        check("rand_polite_ovf", 32'(ovf), 32'd0);

        // Unconstrained random traffic, overflows included
        reset_sync();
        for (int c = 0; c < 300; c++) begin
            rand_inputs(1'b0);
            step("rand_free");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Write-back arbiter that sits directly downstream of the multi-cycle functional units (ALU, memory unit, mul/div, FPU). It captures each unit's one-cycle `finish` pulse with its destination register and result into a per-unit holding register. It then grants one holding register per cycle, round-robin, onto the single register-file write port. It also reports per-unit pending status so issue logic does not re-enable a unit whose previous result has not yet retired.

## Interface
- `NUM_FU`, default 4: number of functional-unit sources. Index 0 = ALU, 1 = mem, 2 = mul/div, 3 = FPU.
- `DATA_W`, default 32: result width.
- `RD_W`, default 5: destination register index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- `fu_finish`  in  NUM_FU  per-unit one-cycle result-valid pulse. Unconditional; units cannot be stalled.
- `fu_rd`  in  NUM_FU*RD_W  per-unit destination register, packed, unit i at [i*RD_W +: RD_W].
- `fu_data`  in  NUM_FU*DATA_W  per-unit result, packed likewise.
- `fu_pending`  out  NUM_FU  holding register i valid. Issue logic must not assert EN to unit i while set.
- `wb_en`  out  1  register-file write enable, registered.
- `wb_rd`  out  RD_W  write address, registered.
- `wb_data`  out  DATA_W  write data, registered.
- `wb_src`  out  log2(NUM_FU)  index of the unit being written, registered, for debug/scoreboard clear.
- `ovf`  out  1  sticky overflow error.

## Operation
- Holding register per unit: `valid`, `rd`, `data`.
- Capture: at a rising edge with `fu_finish[i]`=1:
  - `rd` and `data` load if holding i is empty, or if it is granted in the same cycle. Free and reload occur together.
  - `valid` stays or becomes 1.
- Overflow: `fu_finish[i]`=1 while holding i is valid and not granted this cycle.
  - The new result is discarded and the old entry is kept.
  - `ovf` sets and stays set until reset.
- Arbitration (combinational, one grant per cycle) over valid holding registers:
  - Round-robin starting at `last+1` mod NUM_FU, where `last` is the most recently granted index.
  - `last` updates only on a grant.
  - Ungranted entries keep their valid bit indefinitely; there is no ageing beyond round-robin.
- rd = 0 entries:
  - Still consume a grant slot and free their holding register.
  - Drive `wb_en`=0 for that slot (x0 is never written).
  - `last` still advances.
- Output register:
  - On a grant, the next edge loads `wb_en` (=1 unless rd=0), `wb_rd`, `wb_data` and `wb_src`.
  - With no grant, `wb_en` goes to 0; `wb_rd`, `wb_data` and `wb_src` hold their previous values.
- `fu_pending[i]` = holding valid i (registered state, no combinational path from inputs).

## Timing
- Reset values:
  - all holding valid = 0, `fu_pending` = 0
  - `wb_en` = 0, `wb_rd` = 0, `wb_data` = 0, `wb_src` = 0
  - `ovf` = 0
  - `last` = NUM_FU-1, so unit 0 has first priority.
- Latency: `fu_finish` in cycle T → captured at the end of T → granted in T+1 → `wb_en` high during T+2. Minimum latency is 2 cycles.
- Throughput: one write-back per cycle. Sustained when ≥1 entry is valid.
- Simultaneous finish on k units into empty holding registers: written over k consecutive cycles in round-robin order.
- Same-unit back-to-back:
  - A finish in T+1 while entry i is granted in T+1 is accepted without overflow.
  - The second result writes back no earlier than T+3.
- Reset mid-operation:
  - All holding entries and any in-flight output are discarded immediately (asynchronously).
  - `wb_en` drops without waiting for a clock edge.
- `ovf` is observed one cycle after the offending edge.

## Test plan
- Single result: `fu_finish[1]` pulse with rd=7, data=0xDEADBEEF in cycle 3 → `fu_pending[1]`=1 during cycle 4; `wb_en`=1, `wb_rd`=7, `wb_data`=0xDEADBEEF, `wb_src`=1 during cycle 5 only; `fu_pending[1]`=0 from cycle 5.
- Four-way collision after reset: all `fu_finish` high together with rd=1,2,3,4 → writes rd 1,2,3,4 (src 0,1,2,3) on four consecutive cycles, no `ovf`.
- Fairness:
  - Unit 0 finishes every cycle with immediate regrant.
  - Unit 2 finishes once.
  - → unit 2 written within 2 cycles of its capture.
  - Unit 0 never overflows.
  - Writes alternate 0,2,0,…
- rd=0 drop: `fu_finish[3]` with rd=0, data=0x1234 → `wb_en` stays 0, `fu_pending[3]` clears after 1 cycle, and the next finish on unit 0 is granted normally.
- Overflow:
  - Unit 1 and unit 0 finish in cycle T; unit 0 wins the grant.
  - Unit 1 finishes again in T+1 with data=0xAAAA.
  - → `ovf`=1 from T+2.
  - Original unit-1 data is written and 0xAAAA never appears.
- Reset mid-operation: three entries pending, `rst` pulsed asynchronously between edges → `wb_en` and `fu_pending` are 0 immediately; after reset release, unit 0 has first priority.
